// File: rtl/ahb_dw64_to_32_bridge_pkg.sv
// ----------------------------------------------------------------------------
// ahb_dw64_to_32_bridge_pkg
// Shared constants for the 64-to-32 bit AHB-Lite data-width bridge:
// HTRANS codes, the HSIZE code for a 32-bit beat, bridge state encodings,
// and the size-normalisation helper.
// Optional feature macro used by the bridge: DW_BRIDGE_ERR_EN.
// ----------------------------------------------------------------------------
package ahb_dw64_to_32_bridge_pkg;

   // HTRANS codes driven downstream (only IDLE and NONSEQ are ever issued)
   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

   // HSIZE code of one downstream word beat
   localparam logic [2:0] HSIZE_WORD    = 3'd2;

   // Bridge states (binary, 2 bits)
   localparam logic [1:0] ST_IDLE = 2'b00;  // no transfer in flight
   localparam logic [1:0] ST_A0   = 2'b01;  // first (or only) beat address phase
   localparam logic [1:0] ST_A1   = 2'b10;  // beat0 data phase + beat1 address phase
   localparam logic [1:0] ST_DL   = 2'b11;  // last data phase

   // Upstream sizes above a doubleword collapse to a doubleword.
   function automatic logic [1:0] eff_size(input logic [2:0] size);
      return size[2] ? 2'd3 : size[1:0];
   endfunction

endpackage

// File: rtl/ahb_dw64_to_32_bridge_lane_steer.sv
// ----------------------------------------------------------------------------
// ahb_dw64_to_32_bridge_lane_steer
// Combinational data steering for the 64-to-32 bit bridge.
//   wdata_i     in   2*MDW  upstream write data
//   size3_i     in   1      current transfer is a doubleword (split in two beats)
//   last_beat_i in   1      bridge is in its last data phase
//   addr2_i     in   1      address bit 2 of a <=32-bit transfer
//   rdata_i     in   MDW    downstream read data
//   rd_lo_i     in   MDW    captured beat0 read data of a doubleword read
//   wdata_o     out  MDW    downstream write data
//   rdata_o     out  2*MDW  upstream read data
// ----------------------------------------------------------------------------
module ahb_dw64_to_32_bridge_lane_steer #(
   parameter int MDW = 32
) (
   input  logic [2*MDW-1:0] wdata_i,
   input  logic             size3_i,
   input  logic             last_beat_i,
   input  logic             addr2_i,
   input  logic [MDW-1:0]   rdata_i,
   input  logic [MDW-1:0]   rd_lo_i,
   output logic [MDW-1:0]   wdata_o,
   output logic [2*MDW-1:0] rdata_o
);

   logic hi_sel;

   // Doubleword: low half on beat0, high half on the last beat.
   // Narrow transfer: the lane is picked by address bit 2.
   assign hi_sel  = size3_i ? last_beat_i : addr2_i;
   assign wdata_o = hi_sel ? wdata_i[2*MDW-1:MDW] : wdata_i[MDW-1:0];

   // Narrow reads are replicated so whichever lane the master uses is valid.
   assign rdata_o = size3_i ? {rdata_i, rd_lo_i} : {rdata_i, rdata_i};

endmodule

// File: rtl/ahb_dw64_to_32_bridge.sv
// ----------------------------------------------------------------------------
// ahb_dw64_to_32_bridge
// AHB-Lite data-width bridge from a 64-bit single master to a 32-bit slave
// fabric. Doubleword transfers become two word beats; narrower transfers
// pass through with byte-lane steering. One transfer outstanding at a time.
// Ports:
//   HCLK, HRESET (async, active-high)
//   S_HADDR/S_HTRANS/S_HWRITE/S_HSIZE/S_HWDATA  upstream request (64-bit data)
//   S_HRDATA/S_HREADY                            upstream response
//   M_HADDR/M_HTRANS/M_HWRITE/M_HSIZE/M_HWDATA  downstream request (32-bit data)
//   M_HRDATA/M_HREADY                            downstream response
//   M_HRESP, ERR_CLR, ERR_FLAG, ERR_ADDR         error capture, only with
//                                                DW_BRIDGE_ERR_EN defined
// ----------------------------------------------------------------------------
module ahb_dw64_to_32_bridge
   import ahb_dw64_to_32_bridge_pkg::*;
#(
   parameter int AW  = 32,
   parameter int SDW = 64,
   parameter int MDW = 32
) (
   input  logic           HCLK,
   input  logic           HRESET,
   input  logic [AW-1:0]  S_HADDR,
   input  logic [1:0]     S_HTRANS,
   input  logic           S_HWRITE,
   input  logic [2:0]     S_HSIZE,
   input  logic [SDW-1:0] S_HWDATA,
   output logic [SDW-1:0] S_HRDATA,
   output logic           S_HREADY,
   output logic [AW-1:0]  M_HADDR,
   output logic [1:0]     M_HTRANS,
   output logic           M_HWRITE,
   output logic [2:0]     M_HSIZE,
   output logic [MDW-1:0] M_HWDATA,
   input  logic [MDW-1:0] M_HRDATA,
`ifdef DW_BRIDGE_ERR_EN
   input  logic           M_HRESP,
   input  logic           ERR_CLR,
   output logic           ERR_FLAG,
   output logic [AW-1:0]  ERR_ADDR,
`endif
   input  logic           M_HREADY
);

   logic [1:0]     state_q, state_d;
   logic [AW-1:0]  addr_q;
   logic           write_q;
   logic [1:0]     size_q;
   logic [MDW-1:0] rd_lo_q;

   logic           accept;
   logic           size3;
   logic [AW-1:0]  beat0_addr;
   logic [AW-1:0]  beat1_addr;
   logic           unused_htrans0;

   // NONSEQ and SEQ are told apart by bit 0 only; both start a transfer.
   assign unused_htrans0 = S_HTRANS[0];

   assign size3      = (size_q == 2'd3);
   assign beat0_addr = size3 ? {addr_q[AW-1:3], 3'b000} : addr_q;
   assign beat1_addr = {addr_q[AW-1:3], 3'b100};

   always_comb begin
      case (state_q)
         ST_IDLE: S_HREADY = 1'b1;
         ST_DL:   S_HREADY = M_HREADY;
         default: S_HREADY = 1'b0;
      endcase
   end

   assign accept = S_HTRANS[1] & S_HREADY;

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (accept)   state_d = ST_A0;
         ST_A0:   if (M_HREADY) state_d = size3 ? ST_A1 : ST_DL;
         ST_A1:   if (M_HREADY) state_d = ST_DL;
         // A new request taken in the last data phase goes straight to its
         // address phase, so back-to-back transfers have no idle bubble.
         ST_DL:   if (M_HREADY) state_d = accept ? ST_A0 : ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         state_q <= ST_IDLE;
         addr_q  <= '0;
         write_q <= 1'b0;
         size_q  <= 2'd0;
         rd_lo_q <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            addr_q  <= S_HADDR;
            write_q <= S_HWRITE;
            size_q  <= eff_size(S_HSIZE);
         end
         if (state_q == ST_A1 && M_HREADY) begin
            rd_lo_q <= M_HRDATA;
         end
      end
   end

   // Address-phase outputs come straight from registered state, so a stalled
   // downstream (M_HREADY low) leaves them untouched.
   assign M_HTRANS = (state_q == ST_A0 || state_q == ST_A1) ? HTRANS_NONSEQ : HTRANS_IDLE;
   assign M_HADDR  = (state_q == ST_A1) ? beat1_addr : beat0_addr;
   assign M_HWRITE = write_q;
   assign M_HSIZE  = size3 ? HSIZE_WORD : {1'b0, size_q};

   ahb_dw64_to_32_bridge_lane_steer #(
      .MDW (MDW)
   ) u_lane_steer (
      .wdata_i     (S_HWDATA),
      .size3_i     (size3),
      .last_beat_i (state_q == ST_DL),
      .addr2_i     (addr_q[2]),
      .rdata_i     (M_HRDATA),
      .rd_lo_i     (rd_lo_q),
      .wdata_o     (M_HWDATA),
      .rdata_o     (S_HRDATA)
   );

`ifdef DW_BRIDGE_ERR_EN
   logic          err_flag_q;
   logic [AW-1:0] err_addr_q;
   logic          err_hit;
   logic [AW-1:0] err_beat_addr;

   // Only data phases carry a response: beat0 of a doubleword in A1, and
   // the last (or only) beat in DL.
   assign err_hit       = M_HREADY & M_HRESP & (state_q == ST_A1 || state_q == ST_DL);
   assign err_beat_addr = (state_q == ST_DL && size3) ? beat1_addr : beat0_addr;

   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         err_flag_q <= 1'b0;
         err_addr_q <= '0;
      end else if (err_hit) begin
         // Keep the first failing address; a simultaneous clear discards
         // the old one, so the new error is recorded instead.
         err_flag_q <= 1'b1;
         if (!err_flag_q || ERR_CLR) begin
            err_addr_q <= err_beat_addr;
         end
      end else if (ERR_CLR) begin
         err_flag_q <= 1'b0;
         err_addr_q <= '0;
      end
   end

   assign ERR_FLAG = err_flag_q;
   assign ERR_ADDR = err_addr_q;
`endif

endmodule

// File: tb/tb_ahb_dw64_to_32_bridge.sv
module tb_ahb_dw64_to_32_bridge;

   logic        HCLK = 1'b0;
   logic        HRESET = 1'b0;
   logic [31:0] S_HADDR = '0;
   logic [1:0]  S_HTRANS = 2'b00;
   logic        S_HWRITE = 1'b0;
   logic [2:0]  S_HSIZE = 3'd0;
   logic [63:0] S_HWDATA = '0;
   logic [63:0] S_HRDATA;
   logic        S_HREADY;
   logic [31:0] M_HADDR;
   logic [1:0]  M_HTRANS;
   logic        M_HWRITE;
   logic [2:0]  M_HSIZE;
   logic [31:0] M_HWDATA;
   logic [31:0] M_HRDATA;
   logic        M_HREADY;
`ifdef DW_BRIDGE_ERR_EN
   logic        M_HRESP;
   logic        ERR_CLR = 1'b0;
   logic        ERR_FLAG;
   logic [31:0] ERR_ADDR;
   logic [31:0] err_tgt = 32'hFFFF_FFFF;
`endif

   int checks = 0;
   int failures = 0;

   always #5 HCLK = ~HCLK;

   ahb_dw64_to_32_bridge dut (
      .HCLK     (HCLK),
      .HRESET   (HRESET),
      .S_HADDR  (S_HADDR),
      .S_HTRANS (S_HTRANS),
      .S_HWRITE (S_HWRITE),
      .S_HSIZE  (S_HSIZE),
      .S_HWDATA (S_HWDATA),
      .S_HRDATA (S_HRDATA),
      .S_HREADY (S_HREADY),
      .M_HADDR  (M_HADDR),
      .M_HTRANS (M_HTRANS),
      .M_HWRITE (M_HWRITE),
      .M_HSIZE  (M_HSIZE),
      .M_HWDATA (M_HWDATA),
      .M_HRDATA (M_HRDATA),
`ifdef DW_BRIDGE_ERR_EN
      .M_HRESP  (M_HRESP),
      .ERR_CLR  (ERR_CLR),
      .ERR_FLAG (ERR_FLAG),
      .ERR_ADDR (ERR_ADDR),
`endif
      .M_HREADY (M_HREADY)
   );

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // ---------------- downstream slave model ----------------
   typedef struct {
      logic [31:0] addr;
      logic        write;
      logic [2:0]  size;
      logic [31:0] data;
   } beat_t;

   beat_t       beats[$];
   logic [31:0] mem [bit [31:0]];
   int          wait_pct = 0;
   int          stall_a1 = 0;
   int          lowcnt = 0;

   function automatic logic [31:0] mem_rd(input logic [31:0] a);
      logic [31:0] w;
      w = {a[31:2], 2'b00};
      if (mem.exists(w)) return mem[w];
      return w ^ 32'h5A5A_0F0F;
   endfunction

   logic        snap_ready = 1'b1;
   logic [1:0]  snap_trans = 2'b00;
   logic [31:0] snap_addr = '0, snap_wdata = '0, snap_rdata = '0;
   logic        snap_write = 1'b0;
   logic [2:0]  snap_size = '0;
   logic        pend_valid = 1'b0;
   logic [31:0] pend_addr = '0;
   logic        pend_write = 1'b0;
   logic [2:0]  pend_size = '0;

   initial begin
      beat_t b;
      M_HREADY = 1'b1;
      M_HRDATA = '0;
`ifdef DW_BRIDGE_ERR_EN
      M_HRESP = 1'b0;
`endif
      forever begin
         @(negedge HCLK);
         // Retire what the previous cycle's clock edge completed.
         if (snap_ready && !HRESET) begin
            if (pend_valid) begin
               b.addr  = pend_addr;
               b.write = pend_write;
               b.size  = pend_size;
               b.data  = pend_write ? snap_wdata : snap_rdata;
               if (pend_write) mem[{pend_addr[31:2], 2'b00}] = snap_wdata;
               beats.push_back(b);
            end
            pend_valid = snap_trans[1];
            pend_addr  = snap_addr;
            pend_write = snap_write;
            pend_size  = snap_size;
         end
         if (HRESET) begin
            pend_valid = 1'b0;
            M_HREADY   = 1'b1;
         end else if (pend_valid && stall_a1 > 0 && M_HTRANS[1]) begin
            M_HREADY = 1'b0;
            stall_a1--;
         end else begin
            M_HREADY = !(pend_valid && ($urandom_range(0, 99) < wait_pct));
         end
         if (!M_HREADY) lowcnt++;
         M_HRDATA = (pend_valid && !pend_write && M_HREADY) ? mem_rd(pend_addr) : $urandom();
`ifdef DW_BRIDGE_ERR_EN
         M_HRESP = pend_valid && (pend_addr == err_tgt);
`endif
         #1;
         if (!HRESET) begin
            if (!snap_ready) begin
               check_eq("hold_haddr", 64'(M_HADDR), 64'(snap_addr));
               check_eq("hold_htrans", 64'(M_HTRANS), 64'(snap_trans));
               check_eq("hold_hsize", 64'(M_HSIZE), 64'(snap_size));
            end
            if (!M_HREADY) check_eq("stall_s_hready", 64'(S_HREADY), 64'd0);
         end
         snap_ready = M_HREADY;
         snap_trans = M_HTRANS;
         snap_addr  = M_HADDR;
         snap_write = M_HWRITE;
         snap_size  = M_HSIZE;
         snap_wdata = M_HWDATA;
         snap_rdata = M_HRDATA;
      end
   end

   // ---------------- upstream driver ----------------
   task automatic xfer(input logic [31:0] a, input logic w, input logic [2:0] sz,
                       input logic [63:0] wd, output logic [63:0] rd, output int waits,
                       output bit ok);
      @(posedge HCLK); #1;
      S_HADDR = a; S_HTRANS = 2'b10; S_HWRITE = w; S_HSIZE = sz;
      @(posedge HCLK); #1;
      S_HTRANS = 2'b00; S_HWDATA = wd; lowcnt = 0;
      waits = 0; ok = 0; rd = '0;
      for (int i = 0; i < 60; i++) begin
         @(negedge HCLK); #2;
         if (S_HREADY) begin
            rd = S_HRDATA; ok = 1;
            break;
         end
         waits++;
      end
   endtask

   // Reference: doubleword -> two word beats at the aligned doubleword and
   // +4, low half first; narrow -> one beat at the original address with the
   // lane chosen by addr[2]; reads come back assembled or replicated.
   task automatic run_and_check(input logic [31:0] a, input logic w, input logic [2:0] sz,
                                input logic [63:0] wd, output logic [63:0] rd, output int waits);
      logic [1:0]  es;
      logic [31:0] b0, b1;
      logic [63:0] exp_rd;
      logic [2:0]  exp_sz;
      bit          ok;
      es     = sz[2] ? 2'd3 : sz[1:0];
      b0     = (es == 2'd3) ? {a[31:3], 3'b000} : a;
      b1     = {a[31:3], 3'b100};
      exp_sz = (es == 2'd3) ? 3'd2 : {1'b0, es};
      exp_rd = (es == 2'd3) ? {mem_rd(b1), mem_rd(b0)} : {mem_rd(a), mem_rd(a)};
      beats.delete();
      xfer(a, w, sz, wd, rd, waits, ok);
      check_eq("xfer_done", 64'(ok), 64'd1);
      @(posedge HCLK); @(negedge HCLK); #3;
      check_eq("beat_count", 64'(beats.size()), (es == 2'd3) ? 64'd2 : 64'd1);
      if (beats.size() >= 1) begin
         check_eq("beat0_addr", 64'(beats[0].addr), 64'(b0));
         check_eq("beat0_size", 64'(beats[0].size), 64'(exp_sz));
         check_eq("beat0_write", 64'(beats[0].write), 64'(w));
         if (w) check_eq("beat0_wdata", 64'(beats[0].data),
                         64'((es == 2'd3 || !a[2]) ? wd[31:0] : wd[63:32]));
      end
      if (es == 2'd3 && beats.size() >= 2) begin
         check_eq("beat1_addr", 64'(beats[1].addr), 64'(b1));
         check_eq("beat1_size", 64'(beats[1].size), 64'd2);
         if (w) check_eq("beat1_wdata", 64'(beats[1].data), 64'(wd[63:32]));
      end
      if (!w) check_eq("s_hrdata", rd, exp_rd);
      check_eq("wait_states", 64'(waits), 64'((es == 2'd3 ? 2 : 1) + lowcnt));
      $display("xfer addr=%h write=%0d size=%0d wdata=%h rdata=%h waits=%0d",
               a, w, sz, wd, rd, waits);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog timeout got=running exp=finished");
      failures++;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0] rd;
      int          waits;
      bit          ok;
      logic [31:0] a;
      logic        w;
      logic [2:0]  sz;
      logic [63:0] wd;

      // Reset state
      #1 HRESET = 1'b1;
      #1;
      check_eq("rst_s_hready", 64'(S_HREADY), 64'd1);
      check_eq("rst_m_htrans", 64'(M_HTRANS), 64'd0);
      check_eq("rst_m_haddr", 64'(M_HADDR), 64'd0);
      check_eq("rst_m_hwrite", 64'(M_HWRITE), 64'd0);
      check_eq("rst_m_hsize", 64'(M_HSIZE), 64'd0);
`ifdef DW_BRIDGE_ERR_EN
      check_eq("rst_err_flag", 64'(ERR_FLAG), 64'd0);
      check_eq("rst_err_addr", 64'(ERR_ADDR), 64'd0);
`endif
      repeat (3) @(posedge HCLK);
      #2 HRESET = 1'b0;

      // 1: 32-bit write to the upper lane
      run_and_check(32'h1000_0004, 1'b1, 3'd2, 64'hAAAA_BBBB_CCCC_DDDD, rd, waits);
      check_eq("t1_waits", 64'(waits), 64'd1);

      // 2: 64-bit read assembled from two beats
      mem[32'h2000_0008] = 32'h1111_1111;
      mem[32'h2000_000C] = 32'h2222_2222;
      run_and_check(32'h2000_0008, 1'b0, 3'd3, 64'd0, rd, waits);
      check_eq("t2_rdata", rd, 64'h2222_2222_1111_1111);
      check_eq("t2_waits", 64'(waits), 64'd2);

      // 3: 64-bit write, then a 16-bit read presented during the last data phase
      beats.delete();
      @(posedge HCLK); #1;
      S_HADDR = 32'h3000_0000; S_HTRANS = 2'b10; S_HWRITE = 1'b1; S_HSIZE = 3'd3;
      @(posedge HCLK); #1;
      S_HADDR = 32'h3000_0006; S_HWRITE = 1'b0; S_HSIZE = 3'd1;
      S_HWDATA = 64'h0123_4567_89AB_CDEF;
      ok = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge HCLK); #2;
         if (S_HREADY) begin ok = 1; break; end
      end
      check_eq("t3_first_done", 64'(ok), 64'd1);
      @(posedge HCLK); #1;
      S_HTRANS = 2'b00;
      check_eq("t3_a0_htrans", 64'(M_HTRANS), 64'h2);
      check_eq("t3_a0_haddr", 64'(M_HADDR), 64'h3000_0006);
      check_eq("t3_a0_hsize", 64'(M_HSIZE), 64'd1);
      ok = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge HCLK); #2;
         if (S_HREADY) begin ok = 1; rd = S_HRDATA; break; end
      end
      check_eq("t3_second_done", 64'(ok), 64'd1);
      check_eq("t3_rdata", rd, 64'h0123_4567_0123_4567);
      @(posedge HCLK); @(negedge HCLK); #3;
      check_eq("t3_beats", 64'(beats.size()), 64'd3);
      if (beats.size() == 3) begin
         check_eq("t3_wlo", 64'(beats[0].data), 64'h89AB_CDEF);
         check_eq("t3_whi", 64'(beats[1].data), 64'h0123_4567);
         check_eq("t3_rd_addr", 64'(beats[2].addr), 64'h3000_0006);
      end
      $display("xfer pipelined write 30000000 + read 30000006 rdata=%h", rd);

      // 4: downstream stall of 3 cycles during A1
      stall_a1 = 3;
      run_and_check(32'h2000_0008, 1'b0, 3'd3, 64'd0, rd, waits);
      check_eq("t4_rdata", rd, 64'h2222_2222_1111_1111);
      check_eq("t4_waits", 64'(waits), 64'd5);

      // 5: reset pulse while in A1
      beats.delete();
      @(posedge HCLK); #1;
      S_HADDR = 32'h5000_0010; S_HTRANS = 2'b10; S_HWRITE = 1'b0; S_HSIZE = 3'd3;
      @(posedge HCLK); #1;
      S_HTRANS = 2'b00;
      @(posedge HCLK); #1;
      check_eq("t5_in_a1", 64'(M_HADDR), 64'h5000_0014);
      #1 HRESET = 1'b1;
      #1;
      check_eq("t5_htrans", 64'(M_HTRANS), 64'd0);
      check_eq("t5_s_hready", 64'(S_HREADY), 64'd1);
      check_eq("t5_haddr", 64'(M_HADDR), 64'd0);
      @(posedge HCLK); #2 HRESET = 1'b0;
      @(negedge HCLK); #3;
      check_eq("t5_still_idle", 64'(M_HTRANS), 64'd0);
      check_eq("t5_no_beats", 64'(beats.size()), 64'd0);
      $display("xfer reset abort at 50000010");

`ifdef DW_BRIDGE_ERR_EN
      // 6: error on beat1 of a 64-bit read
      err_tgt = 32'h2000_000C;
      run_and_check(32'h2000_0008, 1'b0, 3'd3, 64'd0, rd, waits);
      err_tgt = 32'hFFFF_FFFF;
      check_eq("t6_err_flag", 64'(ERR_FLAG), 64'd1);
      check_eq("t6_err_addr", 64'(ERR_ADDR), 64'h2000_000C);
      @(posedge HCLK); #1 ERR_CLR = 1'b1;
      @(posedge HCLK); #1 ERR_CLR = 1'b0;
      check_eq("t6_clr_flag", 64'(ERR_FLAG), 64'd0);
      check_eq("t6_clr_addr", 64'(ERR_ADDR), 64'd0);
`endif

      // Random traffic with random downstream waits
      wait_pct = 30;
      for (int n = 0; n < 60; n++) begin
         if ($urandom_range(0, 4) == 0) begin
            beats.delete();
            @(posedge HCLK); #1;
            S_HTRANS = 2'($urandom_range(0, 1));
            S_HADDR  = $urandom();
            @(posedge HCLK); #1;
            S_HTRANS = 2'b00;
            @(negedge HCLK); #3;
            check_eq("no_start_htrans", 64'(M_HTRANS), 64'd0);
            check_eq("no_start_beats", 64'(beats.size()), 64'd0);
         end
         a  = 32'h4000_0000 + 32'($urandom_range(0, 63));
         w  = 1'($urandom_range(0, 1));
         sz = 3'($urandom_range(0, 7));
         wd = {$urandom(), $urandom()};
         run_and_check(a, w, sz, wd, rd, waits);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
